// File: rtl/shift_register_165_pkg.sv
// Shared sizing helpers for the 74HC165 input-chain reader.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package shift_register_165_pkg;

    // Every 74HC165 contributes one byte to the deserialised word.
    localparam int SR_BITS_PER_IC = 8;

    // Word width of a chain of num_ics devices.
    function automatic int sr_width(input int num_ics);
        return num_ics * SR_BITS_PER_IC;
    endfunction

    // Width of a counter that must hold values 0..v-1.
    // The result is never below one bit, so degenerate parameters still elaborate.
    function automatic int sr_cnt_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with a terminal-count flag; shared by phase and poll timing.
// Latency: load takes effect on the next clk_i edge; tc_o is a registered-state decode.
// Backpressure: none; dec_i pauses the count, load_i overrides it.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (counter returns to RST_VAL)
//   load_i        : load load_val_i on the next edge (wins over dec_i)
//   load_val_i    : value to load
//   dec_i         : count down by one per cycle, saturating at zero
//   tc_o          : high while the counter is at zero
module sr_phase_timer #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Saturate at zero so an unattended timer never wraps.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/shift_register_165.sv
// Reads a daisy-chain of 74HC165 PISO registers and presents the word with valid/changed strobes.
// Latency: valid_o rises (2N+1)*PHASE_CYCLES+1 cycles after the IDLE edge that accepts a trigger.
// Backpressure: none; triggers arriving while busy_o=1 are dropped, not queued.
//
// Ports:
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   trigger_i     : read request, only looked at in IDLE
//   serial_i      : Q7 of the 165 nearest the FPGA
//   sclk_o        : shared CP of the chain, idles low
//   pl_n_o        : shared active-low parallel load, idles high
//   data_o        : last complete word, bit N-1 is the first bit shifted in
//   valid_o       : one-cycle strobe coincident with a data_o update
//   changed_o     : qualifies valid_o, high when the new word differs from the previous one
//   busy_o        : high whenever a read is in progress
module shift_register_165
    import shift_register_165_pkg::*;
#(
    parameter int NUM_ICS      = 2,
    parameter int PHASE_CYCLES = 1,
    parameter int POLL_CYCLES  = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              trigger_i,
    input  logic                              serial_i,
    output logic                              sclk_o,
    output logic                              pl_n_o,
    output logic [sr_width(NUM_ICS)-1:0]      data_o,
    output logic                              valid_o,
    output logic                              changed_o,
    output logic                              busy_o
);

    localparam int N   = sr_width(NUM_ICS);
    localparam int BCW = sr_cnt_w(N);
    localparam int PCW = sr_cnt_w(PHASE_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_BIT     = BCW'(N - 1);
    localparam logic [PCW-1:0] PHASE_RELOAD = PCW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SETTLE   = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_SHIFT_HI = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           changed_q, changed_d;
    logic           sclk_q, sclk_d;
    logic           pl_n_q, pl_n_d;
    logic           busy_q, busy_d;

    logic in_phase;
    logic phase_tc;
    logic phase_end;
    logic poll_expire;
    logic start_read;

    // ------------------------------------------------------------------
    // Phase timing: the timer is parked at PHASE_CYCLES-1 while idle and
    // reloaded at the end of every phase, so each phase lasts exactly
    // PHASE_CYCLES cycles including the one on which it ends.
    // ------------------------------------------------------------------
    assign in_phase  = (state_q == S_LOAD)     || (state_q == S_SETTLE) ||
                       (state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI);
    assign phase_end = in_phase && phase_tc;

    sr_phase_timer #(
        .W       (PCW),
        .RST_VAL ('0)
    ) u_phase_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     ((state_q == S_IDLE) || phase_end),
        .load_val_i (PHASE_RELOAD),
        .dec_i      (1'b1),
        .tc_o       (phase_tc)
    );

    assign start_read = (state_q == S_IDLE) && (trigger_i || poll_expire);

    // ------------------------------------------------------------------
    // Poll timer: reset and reload value is POLL_CYCLES, counts down only
    // in IDLE, and fires on the idle cycle where it has reached zero.
    // Any read start reloads it, so a trigger and an expiry landing on
    // the same cycle start a single read.
    // ------------------------------------------------------------------
    if (POLL_CYCLES > 0) begin : g_poll
        localparam int PLW = sr_cnt_w(POLL_CYCLES + 1);
        logic poll_tc;

        sr_phase_timer #(
            .W       (PLW),
            .RST_VAL (PLW'(POLL_CYCLES))
        ) u_poll_timer (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (start_read),
            .load_val_i (PLW'(POLL_CYCLES)),
            .dec_i      (state_q == S_IDLE),
            .tc_o       (poll_tc)
        );

        assign poll_expire = poll_tc && (state_q == S_IDLE);
    end else begin : g_no_poll
        assign poll_expire = 1'b0;
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (start_read) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (phase_end) begin
                    state_d = S_SETTLE;
                end
            end

            // PL is back high for a full phase so Q7 presents the chain MSB
            // before the first sample.
            S_SETTLE: begin
                if (phase_end) begin
                    state_d = S_SHIFT_LO;
                end
            end

            // Sample on the last cycle of the low phase: serial_i has had a
            // whole phase to settle since the previous CP edge or PL release.
            S_SHIFT_LO: begin
                if (phase_end) begin
                    shreg_d = {shreg_q[N-2:0], serial_i};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT_HI;
                    end
                end
            end

            // The chain shifts on the rising CP at the start of this phase;
            // the last bit is sampled without a trailing edge, giving N-1 edges.
            S_SHIFT_HI: begin
                if (phase_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = S_SHIFT_LO;
                end
            end

            S_DONE: begin
                data_d    = shreg_q;
                valid_d   = 1'b1;
                changed_d = (shreg_q != data_q);
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so the registered pins
    // change on the same edge as the state they belong to.
    always_comb begin
        sclk_d = (state_d == S_SHIFT_HI);
        pl_n_d = (state_d != S_LOAD);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            sclk_q    <= 1'b0;
            pl_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            sclk_q    <= sclk_d;
            pl_n_q    <= pl_n_d;
            busy_q    <= busy_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign pl_n_o    = pl_n_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign changed_o = changed_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_shift_register_165.sv
// Bench for the 165 chain reader: three configurations side by side, each with
// a model of the chained 165s and a cycle-level expectation of every output.
// Config 0: P=1 poll off, config 1: P=3 poll off, config 2: P=1 poll every 50 idle cycles.
module tb_shift_register_165;

    localparam int N    = 16;
    localparam int NCFG = 3;

    function automatic int cfg_phase(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    function automatic int cfg_poll(input int g);
        return (g == 2) ? 50 : 0;
    endfunction

    logic             clk;
    logic [NCFG-1:0]  rst_n;
    logic [NCFG-1:0]  trig;
    logic [NCFG-1:0]  ser_w;
    logic [NCFG-1:0]  sclk_w;
    logic [NCFG-1:0]  pl_n_w;
    logic [NCFG-1:0]  valid_w;
    logic [NCFG-1:0]  changed_w;
    logic [NCFG-1:0]  busy_w;
    logic [N-1:0]     data_w [NCFG];
    logic [N-1:0]     pins   [NCFG];

    int n_cmp;
    int n_bad;
    int n_sclk  [NCFG];
    int n_pllow [NCFG];
    logic sclk_prev [NCFG];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUTs plus a model of the 165 chain: PL low loads the pins, a rising CP
    // shifts toward Q7 of the nearest device, which feeds serial_i.
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        logic [N-1:0] chain;

        shift_register_165 #(
            .NUM_ICS      (2),
            .PHASE_CYCLES (cfg_phase(gi)),
            .POLL_CYCLES  (cfg_poll(gi))
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n[gi]),
            .trigger_i (trig[gi]),
            .serial_i  (ser_w[gi]),
            .sclk_o    (sclk_w[gi]),
            .pl_n_o    (pl_n_w[gi]),
            .data_o    (data_w[gi]),
            .valid_o   (valid_w[gi]),
            .changed_o (changed_w[gi]),
            .busy_o    (busy_w[gi])
        );

        always @(posedge sclk_w[gi] or negedge pl_n_w[gi]) begin
            if (!pl_n_w[gi]) chain <= pins[gi];
            else             chain <= {chain[N-2:0], 1'b0};
        end

        assign ser_w[gi] = chain[N-1];
    end

    // Transaction model: tracks how many cycles have passed since the edge that
    // accepted a read; outputs are derived from that age arithmetically.
    bit           m_act  [NCFG];
    int           m_age  [NCFG];
    int           m_idle [NCFG];
    logic [N-1:0] m_word [NCFG];
    logic [N-1:0] m_data [NCFG];
    bit           m_chg  [NCFG];
    bit           m_idle_now;

    always @(posedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (!rst_n[g]) begin
                m_act[g]  = 1'b0;
                m_age[g]  = 0;
                m_idle[g] = 0;
                m_word[g] = '0;
                m_data[g] = '0;
                m_chg[g]  = 1'b0;
            end else begin
                m_idle_now = !m_act[g] || (m_age[g] >= (2*N+1)*cfg_phase(g) + 1);
                if (m_idle_now && (trig[g] ||
                    (cfg_poll(g) > 0 && m_idle[g] == cfg_poll(g)))) begin
                    m_act[g]  = 1'b1;
                    m_age[g]  = 0;
                    m_idle[g] = 0;
                    m_word[g] = pins[g];
                end else begin
                    if (m_act[g])   m_age[g]  = m_age[g] + 1;
                    if (m_idle_now) m_idle[g] = m_idle[g] + 1;
                    if (m_act[g] && m_age[g] == (2*N+1)*cfg_phase(g) + 1) begin
                        m_chg[g]  = (m_word[g] != m_data[g]);
                        m_data[g] = m_word[g];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int g,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[cfg%0d] @%0t: got %h, expected %h", name, g, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        int           p;
        int           r;
        int           t;
        int           ph;
        logic         e_busy, e_pl_n, e_sclk, e_valid, e_chg;
        logic [N-1:0] e_data;
        for (int g = 0; g < NCFG; g++) begin
            p = cfg_phase(g);
            r = (2*N+1) * p;
            if (!rst_n[g]) begin
                e_busy = 0; e_pl_n = 1; e_sclk = 0; e_valid = 0; e_chg = 0; e_data = '0;
            end else begin
                t       = m_age[g];
                ph      = t / p;
                e_busy  = m_act[g] && (t <= r);
                e_pl_n  = !(m_act[g] && (t < p));
                e_sclk  = m_act[g] && (t < r) && (ph >= 2) && (ph % 2 == 1);
                e_valid = m_act[g] && (t == r + 1);
                e_chg   = e_valid && m_chg[g];
                e_data  = m_data[g];
            end
            check("busy_o",    g, 32'(busy_w[g]),    32'(e_busy));
            check("pl_n_o",    g, 32'(pl_n_w[g]),    32'(e_pl_n));
            check("sclk_o",    g, 32'(sclk_w[g]),    32'(e_sclk));
            check("valid_o",   g, 32'(valid_w[g]),   32'(e_valid));
            check("changed_o", g, 32'(changed_w[g]), 32'(e_chg));
            check("data_o",    g, 32'(data_w[g]),    32'(e_data));
            if (sclk_w[g] && !sclk_prev[g]) n_sclk[g]++;
            if (!pl_n_w[g])                 n_pllow[g]++;
            sclk_prev[g] = sclk_w[g];
        end
    endtask

    // Returns the number of cycles until valid_o is seen (0 = already high).
    task automatic wait_valid(input int g, input int budget, output int lat);
        lat = -1;
        for (int j = 0; j <= budget; j++) begin
            if (valid_w[g]) begin
                lat = j;
                break;
            end
            tick();
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid[cfg%0d]: no valid_o within %0d cycles", g, budget);
        end
    endtask

    task automatic one_read(input int g, output int lat);
        trig[g] = 1'b1;
        tick();
        trig[g] = 1'b0;
        wait_valid(g, 400, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int s0;
        int p0;
        int nv;
        int first_v;

        n_cmp = 0;
        n_bad = 0;
        for (int g = 0; g < NCFG; g++) begin
            n_sclk[g]    = 0;
            n_pllow[g]   = 0;
            sclk_prev[g] = 1'b0;
        end
        rst_n   = '0;
        trig    = '0;
        pins[0] = 16'hA5C3;
        pins[1] = 16'h5AA5;
        pins[2] = 16'h1234;
        repeat (3) tick();

        // Reset state
        check("rst_data",  0, 32'(data_w[0]),  32'h0);
        check("rst_pl_n",  0, 32'(pl_n_w[0]),  32'h1);
        check("rst_sclk",  0, 32'(sclk_w[0]),  32'h0);
        check("rst_busy",  0, 32'(busy_w[0]),  32'h0);
        check("rst_valid", 0, 32'(valid_w[0]), 32'h0);
        rst_n = '1;

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        repeat (2) tick();

        // 1. single read, exact latency, CP edge count and PL width
        s0 = n_sclk[0];
        p0 = n_pllow[0];
        one_read(0, lat);
        check("t1_latency", 0, 32'(lat), 32'd34);
        check("t1_data",    0, 32'(data_w[0]), 32'h0000A5C3);
        check("t1_changed", 0, 32'(changed_w[0]), 32'h1);
        check("t1_sclk_rises", 0, 32'(n_sclk[0] - s0), 32'd15);
        check("t1_pl_low_cycles", 0, 32'(n_pllow[0] - p0), 32'd1);

        // 2. unchanged pins, then a single-bit change
        one_read(0, lat);
        check("t2_same_changed", 0, 32'(changed_w[0]), 32'h0);
        check("t2_same_data",    0, 32'(data_w[0]), 32'h0000A5C3);
        pins[0] = 16'hA5C2;
        one_read(0, lat);
        check("t2_diff_changed", 0, 32'(changed_w[0]), 32'h1);
        check("t2_diff_data",    0, 32'(data_w[0]), 32'h0000A5C2);

        // 3. PHASE_CYCLES=3, triggers during the read are ignored
        trig[1] = 1'b1;
        tick();
        nv = 0;
        first_v = -1;
        for (int j = 0; j <= 140; j++) begin
            if (valid_w[1]) begin
                nv++;
                if (first_v < 0) first_v = j;
            end
            if (j == 0)   check("t3_busy_start", 1, 32'(busy_w[1]), 32'h1);
            if (j == 99)  check("t3_busy_end",   1, 32'(busy_w[1]), 32'h1);
            if (j == 100) check("t3_busy_after", 1, 32'(busy_w[1]), 32'h0);
            trig[1] = (j == 4 || j == 39);
            tick();
        end
        trig[1] = 1'b0;
        check("t3_valid_count", 1, 32'(nv), 32'd1);
        check("t3_latency",     1, 32'(first_v), 32'd100);
        check("t3_data",        1, 32'(data_w[1]), 32'h00005AA5);

        // 4. reset in the middle of a read
        rst_n[0] = 1'b0;
        repeat (2) tick();
        rst_n[0] = 1'b1;
        tick();
        pins[0] = 16'h3C5A;
        trig[0] = 1'b1;
        tick();
        trig[0] = 1'b0;
        repeat (20) tick();
        rst_n[0] = 1'b0;
        #1;
        check("t4_abort_busy", 0, 32'(busy_w[0]), 32'h0);
        check("t4_abort_sclk", 0, 32'(sclk_w[0]), 32'h0);
        check("t4_abort_pl_n", 0, 32'(pl_n_w[0]), 32'h1);
        check("t4_abort_data", 0, 32'(data_w[0]), 32'h0);
        repeat (3) tick();
        rst_n[0] = 1'b1;
        nv = 0;
        for (int j = 0; j < 40; j++) begin
            if (valid_w[0]) nv++;
            tick();
        end
        check("t4_no_partial_valid", 0, 32'(nv), 32'd0);
        check("t4_data_still_zero",  0, 32'(data_w[0]), 32'h0);
        one_read(0, lat);
        check("t4_latency", 0, 32'(lat), 32'd34);
        check("t4_data",    0, 32'(data_w[0]), 32'h00003C5A);
        check("t4_changed", 0, 32'(changed_w[0]), 32'h1);

        // 5. poll timer, trigger tied low
        wait_valid(2, 300, lat);
        pins[2] = 16'hBEEF;
        tick();
        wait_valid(2, 300, lat);
        check("t5_period1", 2, 32'(lat + 1), 32'd85);
        check("t5_changed1", 2, 32'(changed_w[2]), 32'h1);
        check("t5_data1",    2, 32'(data_w[2]), 32'h0000BEEF);
        tick();
        wait_valid(2, 300, lat);
        check("t5_period2", 2, 32'(lat + 1), 32'd85);
        check("t5_changed2", 2, 32'(changed_w[2]), 32'h0);
        pins[2] = 16'h0001;
        tick();
        wait_valid(2, 300, lat);
        check("t5_changed3", 2, 32'(changed_w[2]), 32'h1);
        check("t5_data3",    2, 32'(data_w[2]), 32'h00000001);

        // 6. trigger held high: back-to-back reads every 35 cycles
        trig[0] = 1'b1;
        tick();
        wait_valid(0, 200, lat);
        s0 = n_sclk[0];
        for (int k = 0; k < 4; k++) begin
            tick();
            wait_valid(0, 100, lat);
            check("t6_spacing", 0, 32'(lat + 1), 32'd35);
        end
        trig[0] = 1'b0;
        check("t6_sclk_rises", 0, 32'(n_sclk[0] - s0), 32'd60);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
